mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Parametrised multicycle successor to the single-cycle MIPS main decoder.
- Moore FSM that sequences one instruction over 3–5 cycles, driving datapath enables, mux selects and ALUop per state.
- Adds a memory ready handshake (wait states), optional ADDI/J support, illegal-opcode detection and a retired-instruction counter.
- Sits between the instruction register opcode field and the multicycle datapath.

Parameters:
- OPCODE_W, 6: opcode width. Only the low 6 bits are decoded; any higher bits must be 0 or the opcode is illegal.
- ALUOP_W, 2: ALUop width. Values are 00 add, 01 sub, 10 funct; upper bits are zero-padded.
- ENABLE_ADDI, 1: 0 makes opcode 001000 illegal.
- ENABLE_J, 1: 0 makes opcode 000010 illegal.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  instruction opcode; sampled only in DECODE.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory access request.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- memwrite  out  1  memory write.
- irwrite  out  1  instruction register load.
- pcwrite  out  1  unconditional PC load.
- branch  out  1  conditional PC load (ANDed with zero in the datapath).
- pcsrc  out  2  00 ALU, 01 ALUOut, 10 jump target.
- alusrca  out  1  0 = PC, 1 = register A.
- alusrcb  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
- aluop  out  ALUOP_W  ALU operation class.
- regdst  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = memory data, 0 = ALUOut.
- regwrite  out  1  register file write.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- retire  out  1  asserted in the last cycle of each instruction.
- instret  out  CNT_W  count of retired instructions.
- state  out  4  current state, for debug.

Behaviour:
- Reset, while rst_n is low:
  - state = IDLE (0).
  - All outputs are 0.
  - instret = 0.
  - op_q = 0.
- Reset mid-instruction aborts the instruction immediately with no retire.
- State encoding: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, REX 7, RWB 8, BEQ 9, AEX 10, AWB 11, JMP 12. Codes 13–15 go to FETCH on the next edge.
- Transitions:
  - IDLE goes to FETCH.
  - FETCH goes to DECODE when mem_ready, otherwise stays in FETCH.
  - DECODE latches opcode into op_q and branches:
    - 100011 or 101011 go to MEMADR.
    - 000000 goes to REX.
    - 000100 goes to BEQ.
    - 001000 goes to AEX when ENABLE_ADDI.
    - 000010 goes to JMP when ENABLE_J.
    - Anything else goes to FETCH, with illegal_op = 1 in that DECODE cycle.
  - MEMADR goes to MEMRD if op_q = 100011, else to MEMWR.
  - MEMRD goes to MEMWB when mem_ready, otherwise waits.
  - MEMWR goes to FETCH when mem_ready, otherwise waits.
  - MEMWB, RWB, BEQ, AWB and JMP go to FETCH.
  - REX goes to RWB; AEX goes to AWB.
- Outputs are a function of state only (Moore), apart from the mem_ready gating noted below. Any output not listed for a state is 0.
  - FETCH: mem_req = 1, alusrcb = 01, irwrite = mem_ready, pcwrite = mem_ready.
  - DECODE: alusrcb = 11.
  - MEMADR and AEX: alusrca = 1, alusrcb = 10.
  - MEMRD: mem_req = 1, iord = 1.
  - MEMWB: memtoreg = 1, regwrite = 1.
  - MEMWR: mem_req = 1, iord = 1, memwrite = 1. memwrite is held for the whole wait.
  - REX: alusrca = 1, aluop = 10.
  - RWB: regdst = 1, regwrite = 1.
  - BEQ: alusrca = 1, aluop = 01, branch = 1, pcsrc = 01.
  - AWB: regwrite = 1.
  - JMP: pcsrc = 10, pcwrite = 1.
- retire is asserted in MEMWB, RWB, BEQ, AWB, JMP, and in MEMWR when mem_ready. It is not asserted on an illegal opcode.
- instret increments by 1 at the clock edge ending each retire cycle and wraps modulo 2^CNT_W.
- opcode changing outside DECODE has no effect, because op_q is the only value used after DECODE.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Cycle counts with no wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Decomposition:
- Shared package mc_pkg holds:
  - the state enumeration and codes;
  - the opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - the ALUop constants and the pcsrc/alusrcb encodings.
- One sub-module, mc_out_decode: combinational decode of state plus mem_ready to all control outputs. The FSM, op_q and the counter stay in the top level.

Test Plan:
- Reset, then lw (100011) with mem_ready = 1: state goes IDLE→1→2→3→4→5→1. At state 5, memtoreg = 1 and regwrite = 1; instret = 1 after 6 cycles.
- sw (101011) with mem_ready low for 3 cycles in MEMWR: memwrite = 1 for 4 cycles, retire pulses once on the ready cycle, instret increments by 1.
- R-type (000000): REX shows aluop = 10, alusrca = 1; RWB shows regdst = 1, regwrite = 1. beq: branch = 1, pcsrc = 01, aluop = 01 for exactly one cycle.
- mem_ready = 0 for 2 cycles in FETCH: irwrite and pcwrite stay 0 until the ready cycle, then pulse once; DECODE follows.
- With ENABLE_J = 0, opcode 000010, and separately opcode 111111: illegal_op pulses in DECODE, the next state is FETCH, instret is unchanged.
- rst_n dropped mid-MEMRD: all outputs 0 immediately, instret = 0. After release, IDLE then FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS controller: state codes, opcodes,
// ALUop classes and datapath mux encodings.
package mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE   = 4'd0;
    localparam state_t S_FETCH  = 4'd1;
    localparam state_t S_DECODE = 4'd2;
    localparam state_t S_MEMADR = 4'd3;
    localparam state_t S_MEMRD  = 4'd4;
    localparam state_t S_MEMWB  = 4'd5;
    localparam state_t S_MEMWR  = 4'd6;
    localparam state_t S_REX    = 4'd7;
    localparam state_t S_RWB    = 4'd8;
    localparam state_t S_BEQ    = 4'd9;
    localparam state_t S_AEX    = 4'd10;
    localparam state_t S_AWB    = 4'd11;
    localparam state_t S_JMP    = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

endpackage

// File: rtl/mc_out_decode.sv
// Moore control-output decode: state plus mem_ready (FETCH/MEMWR gating only)
// to every datapath enable, mux select and the retire strobe.
module mc_out_decode
    import mc_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic       i_mem_ready,
    output logic       o_mem_req,
    output logic       o_iord,
    output logic       o_memwrite,
    output logic       o_irwrite,
    output logic       o_pcwrite,
    output logic       o_branch,
    output logic [1:0] o_pcsrc,
    output logic       o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_aluop,
    output logic       o_regdst,
    output logic       o_memtoreg,
    output logic       o_regwrite,
    output logic       o_retire
);

    always_comb begin
        o_mem_req  = 1'b0;
        o_iord     = 1'b0;
        o_memwrite = 1'b0;
        o_irwrite  = 1'b0;
        o_pcwrite  = 1'b0;
        o_branch   = 1'b0;
        o_pcsrc    = PCSRC_ALU;
        o_alusrca  = 1'b0;
        o_alusrcb  = SRCB_B;
        o_aluop    = ALUOP_ADD;
        o_regdst   = 1'b0;
        o_memtoreg = 1'b0;
        o_regwrite = 1'b0;
        o_retire   = 1'b0;
        case (i_state)
            S_FETCH: begin
                o_mem_req = 1'b1;
                o_alusrcb = SRCB_FOUR;
                o_irwrite = i_mem_ready;
                o_pcwrite = i_mem_ready;
            end
            S_DECODE: o_alusrcb = SRCB_SHIMM;
            S_MEMADR, S_AEX: begin
                o_alusrca = 1'b1;
                o_alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                o_mem_req = 1'b1;
                o_iord    = 1'b1;
            end
            S_MEMWB: begin
                o_memtoreg = 1'b1;
                o_regwrite = 1'b1;
                o_retire   = 1'b1;
            end
            // memwrite stays high through the wait; the store retires on the ready cycle
            S_MEMWR: begin
                o_mem_req  = 1'b1;
                o_iord     = 1'b1;
                o_memwrite = 1'b1;
                o_retire   = i_mem_ready;
            end
            S_REX: begin
                o_alusrca = 1'b1;
                o_aluop   = ALUOP_FUNCT;
            end
            S_RWB: begin
                o_regdst   = 1'b1;
                o_regwrite = 1'b1;
                o_retire   = 1'b1;
            end
            S_BEQ: begin
                o_alusrca = 1'b1;
                o_aluop   = ALUOP_SUB;
                o_branch  = 1'b1;
                o_pcsrc   = PCSRC_ALUOUT;
                o_retire  = 1'b1;
            end
            S_AWB: begin
                o_regwrite = 1'b1;
                o_retire   = 1'b1;
            end
            S_JMP: begin
                o_pcsrc   = PCSRC_JUMP;
                o_pcwrite = 1'b1;
                o_retire  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: sequencing FSM, latched opcode, illegal-opcode
// detection and retired-instruction counter around the output decode.
//
// state  | meaning
// IDLE   | post-reset, one cycle before first fetch
// FETCH  | read instruction, wait for mem_ready, load IR and PC+4
// DECODE | latch opcode, compute branch target, dispatch
// MEMADR | lw/sw effective address
// MEMRD  | lw data read (waits on mem_ready)
// MEMWB  | lw register write-back
// MEMWR  | sw data write (waits on mem_ready)
// REX    | R-type execute
// RWB    | R-type write-back to rd
// BEQ    | branch compare and conditional PC load
// AEX    | addi execute
// AWB    | addi write-back to rt
// JMP    | jump PC load
module mc_controller
    import mc_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 2,
    parameter bit ENABLE_ADDI = 1'b1,
    parameter bit ENABLE_J    = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                iord,
    output logic                memwrite,
    output logic                irwrite,
    output logic                pcwrite,
    output logic                branch,
    output logic [1:0]          pcsrc,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic [ALUOP_W-1:0]  aluop,
    output logic                regdst,
    output logic                memtoreg,
    output logic                regwrite,
    output logic                illegal_op,
    output logic                retire,
    output logic [CNT_W-1:0]    instret,
    output logic [3:0]          state
);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [5:0]       r_op_q;
    logic [CNT_W-1:0] r_instret;
    logic [5:0]       w_op6;
    logic             w_hi_zero;
    logic             w_illegal;
    logic             w_retire;
    logic [1:0]       w_aluop;

    // opcode bits above the decoded six must be zero for a legal instruction
    assign w_op6     = opcode[5:0];
    assign w_hi_zero = ((opcode >> 6) == '0);

    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            S_IDLE:  w_next = S_FETCH;
            S_FETCH: if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                w_next = S_FETCH;
                if (!w_hi_zero) begin
                    w_illegal = 1'b1;
                end else begin
                    case (w_op6)
                        OP_LW, OP_SW: w_next = S_MEMADR;
                        OP_RTYPE:     w_next = S_REX;
                        OP_BEQ:       w_next = S_BEQ;
                        OP_ADDI: if (ENABLE_ADDI) w_next = S_AEX; else w_illegal = 1'b1;
                        OP_J:    if (ENABLE_J)    w_next = S_JMP; else w_illegal = 1'b1;
                        default:      w_illegal = 1'b1;
                    endcase
                end
            end
            S_MEMADR: w_next = (r_op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) w_next = S_FETCH;
            S_REX:    w_next = S_RWB;
            S_AEX:    w_next = S_AWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op_q    <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) r_op_q <= w_op6;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
        end
    end

    mc_out_decode u_out_decode (
        .i_state     (r_state),
        .i_mem_ready (mem_ready),
        .o_mem_req   (mem_req),
        .o_iord      (iord),
        .o_memwrite  (memwrite),
        .o_irwrite   (irwrite),
        .o_pcwrite   (pcwrite),
        .o_branch    (branch),
        .o_pcsrc     (pcsrc),
        .o_alusrca   (alusrca),
        .o_alusrcb   (alusrcb),
        .o_aluop     (w_aluop),
        .o_regdst    (regdst),
        .o_memtoreg  (memtoreg),
        .o_regwrite  (regwrite),
        .o_retire    (w_retire)
    );

    assign aluop      = ALUOP_W'(w_aluop);
    assign retire     = w_retire;
    assign illegal_op = w_illegal;
    assign instret    = r_instret;
    assign state      = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: cycle table for the default build, plus
// hand sequences for reset abort, disabled J and a narrow wrapping counter.
module tb_mc_controller;

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [17:0] cw;
        logic [31:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, mem_ready;
    logic [5:0]  opcode;
    logic        mem_req, iord, memwrite, irwrite, pcwrite, branch;
    logic [1:0]  pcsrc, alusrcb, aluop;
    logic        alusrca, regdst, memtoreg, regwrite, illegal_op, retire;
    logic [31:0] instret;
    logic [3:0]  state;

    logic        rst2_n, rdy2;
    logic [5:0]  op2;
    logic        m2_req, m2_iord, m2_mw, m2_irw, m2_pcw, m2_br;
    logic [1:0]  m2_pcsrc, m2_srcb, m2_aluop;
    logic        m2_srca, m2_rdst, m2_m2r, m2_rw, m2_ill, m2_ret;
    logic [1:0]  m2_instret;
    logic [3:0]  m2_state;

    mc_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .pcwrite(pcwrite), .branch(branch), .pcsrc(pcsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .illegal_op(illegal_op), .retire(retire),
        .instret(instret), .state(state)
    );

    mc_controller #(.ENABLE_J(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .opcode(op2), .mem_ready(rdy2),
        .mem_req(m2_req), .iord(m2_iord), .memwrite(m2_mw), .irwrite(m2_irw),
        .pcwrite(m2_pcw), .branch(m2_br), .pcsrc(m2_pcsrc), .alusrca(m2_srca),
        .alusrcb(m2_srcb), .aluop(m2_aluop), .regdst(m2_rdst), .memtoreg(m2_m2r),
        .regwrite(m2_rw), .illegal_op(m2_ill), .retire(m2_ret),
        .instret(m2_instret), .state(m2_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    function automatic logic [17:0] cw(input logic req, input logic io, input logic mw,
                                       input logic irw, input logic pcw, input logic br,
                                       input logic [1:0] psrc, input logic sa,
                                       input logic [1:0] sb, input logic [1:0] aop,
                                       input logic rd, input logic m2r, input logic rw,
                                       input logic ill, input logic ret);
        return {req, io, mw, irw, pcw, br, psrc, sa, sb, aop, rd, m2r, rw, ill, ret};
    endfunction

    function automatic logic [17:0] act_cw();
        return {mem_req, iord, memwrite, irwrite, pcwrite, branch, pcsrc, alusrca,
                alusrcb, aluop, regdst, memtoreg, regwrite, illegal_op, retire};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                       input logic [17:0] c, input logic [31:0] n);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.cw = c; v.cnt = n;
        vecs.push_back(v);
    endtask

    logic [17:0] e_zero, e_fetch_w, e_fetch_r, e_dec, e_dec_ill, e_adr, e_rd, e_mwb;
    logic [17:0] e_wr_w, e_wr_r, e_rex, e_rwb, e_beq, e_awb, e_jmp;

    initial begin
        //            req io mw irw pcw br psrc sa sb aop rd m2r rw ill ret
        e_zero    = '0;
        e_fetch_w = cw(1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, 0, 0, 0, 0, 0);
        e_fetch_r = cw(1, 0, 0, 1, 1, 0, 2'd0, 0, 2'd1, 2'd0, 0, 0, 0, 0, 0);
        e_dec     = cw(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd3, 2'd0, 0, 0, 0, 0, 0);
        e_dec_ill = cw(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd3, 2'd0, 0, 0, 0, 1, 0);
        e_adr     = cw(0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd2, 2'd0, 0, 0, 0, 0, 0);
        e_rd      = cw(1, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0);
        e_mwb     = cw(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 1, 1, 0, 1);
        e_wr_w    = cw(1, 1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0);
        e_wr_r    = cw(1, 1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 1);
        e_rex     = cw(0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd2, 0, 0, 0, 0, 0);
        e_rwb     = cw(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 0, 1, 0, 1);
        e_beq     = cw(0, 0, 0, 0, 0, 1, 2'd1, 1, 2'd0, 2'd1, 0, 0, 0, 0, 1);
        e_awb     = cw(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 1, 0, 1);
        e_jmp     = cw(0, 0, 0, 0, 1, 0, 2'd2, 0, 2'd0, 2'd0, 0, 0, 0, 0, 1);

        // lw, no wait states
        add(6'h00, 1, 4'd0,  e_zero,    0);
        add(6'h00, 1, 4'd1,  e_fetch_r, 0);
        add(6'h23, 1, 4'd2,  e_dec,     0);
        add(6'h2b, 1, 4'd3,  e_adr,     0);
        add(6'h2b, 1, 4'd4,  e_rd,      0);
        add(6'h00, 1, 4'd5,  e_mwb,     0);
        // sw, three wait cycles; live opcode = lw in MEMADR must not matter
        add(6'h00, 1, 4'd1,  e_fetch_r, 1);
        add(6'h2b, 1, 4'd2,  e_dec,     1);
        add(6'h23, 0, 4'd3,  e_adr,     1);
        add(6'h00, 0, 4'd6,  e_wr_w,    1);
        add(6'h00, 0, 4'd6,  e_wr_w,    1);
        add(6'h00, 0, 4'd6,  e_wr_w,    1);
        add(6'h00, 1, 4'd6,  e_wr_r,    1);
        // fetch with two wait cycles, then R-type
        add(6'h00, 0, 4'd1,  e_fetch_w, 2);
        add(6'h00, 0, 4'd1,  e_fetch_w, 2);
        add(6'h00, 1, 4'd1,  e_fetch_r, 2);
        add(6'h00, 1, 4'd2,  e_dec,     2);
        add(6'h3f, 1, 4'd7,  e_rex,     2);
        add(6'h3f, 1, 4'd8,  e_rwb,     2);
        // beq, mem_ready low in BEQ is ignored
        add(6'h00, 1, 4'd1,  e_fetch_r, 3);
        add(6'h04, 1, 4'd2,  e_dec,     3);
        add(6'h04, 0, 4'd9,  e_beq,     3);
        // addi
        add(6'h00, 1, 4'd1,  e_fetch_r, 4);
        add(6'h08, 1, 4'd2,  e_dec,     4);
        add(6'h00, 1, 4'd10, e_adr,     4);
        add(6'h00, 1, 4'd11, e_awb,     4);
        // j
        add(6'h00, 1, 4'd1,  e_fetch_r, 5);
        add(6'h02, 1, 4'd2,  e_dec,     5);
        add(6'h00, 1, 4'd12, e_jmp,     5);
        // illegal opcode 111111
        add(6'h00, 1, 4'd1,  e_fetch_r, 6);
        add(6'h3f, 1, 4'd2,  e_dec_ill, 6);
        add(6'h00, 1, 4'd1,  e_fetch_r, 6);
        // lw stalled in MEMRD, to be aborted by reset
        add(6'h23, 1, 4'd2,  e_dec,     6);
        add(6'h00, 1, 4'd3,  e_adr,     6);
        add(6'h00, 0, 4'd4,  e_rd,      6);

        rst_n = 1'b0; rst2_n = 1'b0;
        opcode = '0; mem_ready = 1'b1;
        op2 = '0; rdy2 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", {28'd0, state}, 32'd0);
        chk("reset_outputs", {14'd0, act_cw()}, {14'd0, e_zero});
        chk("reset_instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            opcode    = vecs[i].op;
            mem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d_state", i), {28'd0, state}, {28'd0, vecs[i].st});
            chk($sformatf("v%0d_ctrl", i), {14'd0, act_cw()}, {14'd0, vecs[i].cw});
            chk($sformatf("v%0d_instret", i), instret, vecs[i].cnt);
            @(negedge clk);
        end

        // still stalled in MEMRD; asynchronous reset must clear everything at once
        mem_ready = 1'b0;
        #1;
        chk("pre_abort_state", {28'd0, state}, 32'd4);
        rst_n = 1'b0;
        #1;
        chk("abort_state", {28'd0, state}, 32'd0);
        chk("abort_outputs", {14'd0, act_cw()}, {14'd0, e_zero});
        chk("abort_instret", instret, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_abort_idle", {28'd0, state}, 32'd0);
        @(negedge clk);
        #1;
        chk("post_abort_fetch", {28'd0, state}, 32'd1);

        // ENABLE_J = 0 build with a 2-bit counter
        @(negedge clk);
        rst2_n = 1'b1;
        rdy2   = 1'b1;
        #1;
        chk("nj_idle", {28'd0, m2_state}, 32'd0);
        @(negedge clk);
        #1;
        chk("nj_fetch", {28'd0, m2_state}, 32'd1);
        @(negedge clk);
        op2 = 6'b000010;
        #1;
        chk("nj_decode", {28'd0, m2_state}, 32'd2);
        chk("nj_illegal", {31'd0, m2_ill}, 32'd1);
        chk("nj_noretire", {31'd0, m2_ret}, 32'd0);
        @(negedge clk);
        #1;
        chk("nj_next_fetch", {28'd0, m2_state}, 32'd1);
        chk("nj_instret", {30'd0, m2_instret}, 32'd0);
        chk("nj_illegal_pulse", {31'd0, m2_ill}, 32'd0);

        for (int k = 0; k < 4; k++) begin
            op2 = 6'b000100;
            @(negedge clk);
            @(negedge clk);
            #1;
            chk($sformatf("wrap%0d_beq", k), {28'd0, m2_state}, 32'd9);
            chk($sformatf("wrap%0d_retire", k), {31'd0, m2_ret}, 32'd1);
            @(negedge clk);
            #1;
            chk($sformatf("wrap%0d_instret", k), {30'd0, m2_instret}, (k + 1) % 4);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
